control_sequencer: RTL and testbench

Hardwired Mini SRC control unit that sits directly upstream of the register select/encode stage. It steps a T-state machine through instruction fetch and per-opcode execute sequences. Each cycle it drives the Gra/Grb/Grc/Rin/Rout/BAout selects, the datapath enables, the ALU op and the memory strobes, waiting on a memory ready handshake. Opcode is IR[31:27]; the constant field is IR[18:0].

---
 rtl/control_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: T-state fetch/execute sequencer that drives
// the datapath enables, register-select controls, ALU op and memory strobes.
module control_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic [31:0] csign,
  output logic        run,
  output logic        done,
  output logic        fault,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [4:0] w_op;
  logic [4:0] w_imm_op;
  logic       w_is_alu, w_is_imm, w_is_ldi, w_is_ld, w_is_st;
  logic       w_is_nop, w_is_halt, w_legal;
  logic       w_wait, w_timeout;
  logic       w_unused_ir;

  assign w_op        = ir[31:27];
  assign csign       = {{13{ir[18]}}, ir[18:0]};
  assign w_unused_ir = ^ir[26:19];

  // Opcode classification and immediate-form ALU op mapping
  always_comb begin
    w_is_alu  = (w_op >= 5'd3) && (w_op <= 5'd11);
    w_is_imm  = (w_op >= 5'd12) && (w_op <= 5'd14);
    w_is_ldi  = (w_op == 5'b00001);
    w_is_ld   = (w_op == 5'b00000);
    w_is_st   = (w_op == 5'b00010);
    w_is_nop  = (w_op == 5'b11010);
    w_is_halt = (w_op == 5'b11011);
    w_legal   = w_is_alu || w_is_imm || w_is_ldi || w_is_ld || w_is_st;
    case (w_op)
      5'b01100: w_imm_op = 5'b00011;
      5'b01101: w_imm_op = 5'b00101;
      5'b01110: w_imm_op = 5'b00110;
      default:  w_imm_op = 5'b00011;
    endcase
  end

  // Only T1, ld T6 and st T7 wait on memory; the counter is zero on entry to each
  assign w_wait    = (r_state == S_T1) ||
                     ((r_state == S_T6) && w_is_ld) ||
                     ((r_state == S_T7) && w_is_st);
  assign w_timeout = !mem_ready && (({1'b0, r_wait_cnt} + 9'd1) >= TIMEOUT_LIM);

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory wait counter
  always_ff @(posedge clk) begin
    if (clr || !w_wait || mem_ready) begin
      r_wait_cnt <= 8'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1: begin
        if (mem_ready)      w_next = S_T2;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_T1;
      end
      S_T2: begin
        if (w_is_halt)    w_next = S_HALT;
        else if (w_legal) w_next = S_T3;
        else              w_next = S_T0;
      end
      S_T3: w_next = S_T4;
      S_T4: w_next = S_T5;
      S_T5: w_next = (w_is_ld || w_is_st) ? S_T6 : S_T0;
      S_T6: begin
        if (!w_is_ld)       w_next = S_T7;
        else if (mem_ready) w_next = S_T7;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_T6;
      end
      S_T7: begin
        if (!w_is_st)       w_next = S_T0;
        else if (mem_ready) w_next = S_T0;
        else if (w_timeout) w_next = S_FAULT;
        else                w_next = S_T7;
      end
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore output decode; only the st T7 done also looks at mem_ready
  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    PCin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    Cout = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; alu_op = 5'b00000;
    run = 1'b0; done = 1'b0; fault = 1'b0; illegal = 1'b0;
    case (r_state)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        if (!w_legal && !w_is_halt) begin
          done    = 1'b1;
          illegal = !w_is_nop;
        end else begin
          done    = 1'b0;
          illegal = 1'b0;
        end
      end
      S_T3: begin
        run = 1'b1; Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1;
      end
      S_T4: begin
        run = 1'b1; Zin = 1'b1;
        if (w_is_alu) begin
          Grc = 1'b1; Rout = 1'b1; BAout = 1'b1; alu_op = w_op;
        end else if (w_is_imm) begin
          Cout = 1'b1; alu_op = w_imm_op;
        end else begin
          Cout = 1'b1; alu_op = 5'b00011;
        end
      end
      S_T5: begin
        run = 1'b1; Zlowout = 1'b1;
        if (w_is_ld || w_is_st) begin
          MARin = 1'b1;
        end else begin
          Gra = 1'b1; Rin = 1'b1; done = 1'b1;
        end
      end
      S_T6: begin
        run = 1'b1; MDRin = 1'b1;
        if (w_is_ld) begin
          Read = 1'b1;
        end else begin
          Gra = 1'b1; Rout = 1'b1; BAout = 1'b1;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (w_is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
        end else begin
          Write = 1'b1; done = mem_ready;
        end
      end
      S_FAULT: fault = 1'b1;
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded random bench for control_sequencer: a per-instruction micro-step
// model predicts every cycle's control word; a negedge monitor compares.
module tb_control_sequencer;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic clr, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRin, MDRout, IRin, Yin, Cout;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic [31:0] csign;
  logic run, done, fault, illegal;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Cout(Cout), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .csign(csign),
    .run(run), .done(done), .fault(fault), .illegal(illegal)
  );

  typedef struct packed {
    logic PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRin, MDRout, IRin, Yin, Cout;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0] alu_op;
    logic run, done, fault, illegal;
  } cw_t;

  typedef struct packed {
    cw_t         cw;
    logic [31:0] cs;
  } exp_t;

  exp_t  sb_q[$];
  cw_t   seq_cw[$];
  logic  seq_rdy[$];
  int    end_kind;
  int    n_vec = 0;
  int    n_err = 0;
  logic [31:0] cur_ir;
  cw_t   got;

  assign got = {PCout, MARin, IncPC, Zin, Zlowout, PCin, MDRin, MDRout, IRin, Yin,
                Cout, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op,
                run, done, fault, illegal};

  function automatic logic [31:0] sext19(input logic [31:0] v);
    int x;
    x = int'(v[18:0]);
    if (v[18]) x = x - 524288;
    return 32'(x);
  endfunction

  // One clock period: drive inputs just after the edge and predict this period's outputs
  task automatic cyc(input cw_t w, input logic rdy, input logic c);
    exp_t e;
    @(posedge clk);
    #1;
    clr = c; mem_ready = rdy; ir = cur_ir;
    e.cw = w; e.cs = sext19(cur_ir);
    sb_q.push_back(e);
  endtask

  task automatic push(input cw_t w, input logic rdy);
    seq_cw.push_back(w);
    seq_rdy.push_back(rdy);
  endtask

  // A memory wait of s low cycles: times out after TO low cycles
  task automatic mem_wait(input cw_t w, input int s, input logic done_on_ready,
                          output logic timed_out);
    cw_t wd;
    int  lows;
    lows = (s < TO) ? s : TO;
    for (int i = 0; i < lows; i++) push(w, 1'b0);
    if (s >= TO) begin
      end_kind  = 2;
      timed_out = 1'b1;
    end else begin
      wd = w; wd.done = done_on_ready;
      push(wd, 1'b1);
      timed_out = 1'b0;
    end
  endtask

  // Reference: the list of control words an instruction produces, one per cycle
  task automatic gen_seq(input logic [31:0] v, input int s1, input int s6, input int s7);
    int   op;
    logic to;
    logic alu, imm, ldi, ld, st, nop, hlt;
    logic [4:0] imm_ops[3];
    cw_t  w;
    imm_ops[0] = 5'b00011; imm_ops[1] = 5'b00101; imm_ops[2] = 5'b00110;
    op  = int'(v[31:27]);
    alu = (op >= 3 && op <= 11); imm = (op >= 12 && op <= 14);
    ldi = (op == 1); ld = (op == 0); st = (op == 2); nop = (op == 26); hlt = (op == 27);
    seq_cw.delete(); seq_rdy.delete(); end_kind = 0;

    w = '0; w.run = 1'b1; w.PCout = 1'b1; w.MARin = 1'b1; w.IncPC = 1'b1; w.Zin = 1'b1;
    push(w, 1'($urandom_range(0, 1)));
    w = '0; w.run = 1'b1; w.Zlowout = 1'b1; w.PCin = 1'b1; w.Read = 1'b1; w.MDRin = 1'b1;
    mem_wait(w, s1, 1'b0, to);
    if (to) return;
    w = '0; w.run = 1'b1; w.MDRout = 1'b1; w.IRin = 1'b1;
    if (!(alu || imm || ldi || ld || st || hlt)) begin
      w.done = 1'b1; w.illegal = !nop;
    end
    push(w, 1'($urandom_range(0, 1)));
    if (hlt) begin end_kind = 1; return; end
    if (!(alu || imm || ldi || ld || st)) return;

    w = '0; w.run = 1'b1; w.Grb = 1'b1; w.Rout = 1'b1; w.BAout = 1'b1; w.Yin = 1'b1;
    push(w, 1'($urandom_range(0, 1)));
    w = '0; w.run = 1'b1; w.Zin = 1'b1;
    if (alu) begin
      w.Grc = 1'b1; w.Rout = 1'b1; w.BAout = 1'b1; w.alu_op = v[31:27];
    end else begin
      w.Cout = 1'b1; w.alu_op = imm ? imm_ops[op - 12] : 5'b00011;
    end
    push(w, 1'($urandom_range(0, 1)));
    w = '0; w.run = 1'b1; w.Zlowout = 1'b1;
    if (ld || st) w.MARin = 1'b1;
    else begin w.Gra = 1'b1; w.Rin = 1'b1; w.done = 1'b1; end
    push(w, 1'($urandom_range(0, 1)));
    if (!(ld || st)) return;

    if (ld) begin
      w = '0; w.run = 1'b1; w.Read = 1'b1; w.MDRin = 1'b1;
      mem_wait(w, s6, 1'b0, to);
      if (to) return;
      w = '0; w.run = 1'b1; w.MDRout = 1'b1; w.Gra = 1'b1; w.Rin = 1'b1; w.done = 1'b1;
      push(w, 1'($urandom_range(0, 1)));
    end else begin
      w = '0; w.run = 1'b1; w.Gra = 1'b1; w.Rout = 1'b1; w.BAout = 1'b1; w.MDRin = 1'b1;
      push(w, 1'($urandom_range(0, 1)));
      w = '0; w.run = 1'b1; w.Write = 1'b1;
      mem_wait(w, s7, 1'b1, to);
    end
  endtask

  task automatic reset_tail();
    cyc('0, 1'($urandom_range(0, 1)), 1'b1);
    cyc('0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Run one instruction; abort_at >= 0 raises clr in that step of the sequence
  task automatic run_instr(input logic [31:0] v, input int s1, input int s6,
                           input int s7, input int abort_at);
    cw_t sink;
    cur_ir = v;
    gen_seq(v, s1, s6, s7);
    for (int i = 0; i < seq_cw.size(); i++) begin
      if (i == abort_at) begin
        cyc(seq_cw[i], seq_rdy[i], 1'b1);
        reset_tail();
        return;
      end
      cyc(seq_cw[i], seq_rdy[i], 1'b0);
    end
    if (end_kind != 0) begin
      sink = '0; sink.fault = (end_kind == 2);
      repeat (3) cyc(sink, 1'($urandom_range(0, 1)), 1'b0);
      cyc(sink, 1'($urandom_range(0, 1)), 1'b1);
      reset_tail();
    end
  endtask

  // Monitor: compare every period's outputs against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (got !== e.cw || csign !== e.cs) begin
          n_err++;
          $display("FAIL vec%0d ir=%h ctl got=%h exp=%h csign got=%h exp=%h",
                   n_vec, ir, got, e.cw, csign, e.cs);
        end
      end
    end
  end

  initial begin : stim
    int op, r, s1, s6, s7, ab;
    clr = 1'b1; mem_ready = 1'b0; ir = 32'h0; cur_ir = 32'h0;
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);

    run_instr(32'h19890000, 0, 0, 0, -1);   // add R3,R1,R2
    run_instr(32'h610FFFFB, 0, 0, 0, -1);   // addi R2,R1,-5
    run_instr(32'h00800010, 3, 2, 0, -1);   // ld with stalls
    run_instr(32'h10800004, 0, 0, TO, -1);  // st timing out in T7
    run_instr(32'hF8000000, 0, 0, 0, -1);   // illegal opcode
    run_instr(32'hD0000000, 1, 0, 0, -1);   // nop
    run_instr(32'h19890000, 0, 0, 0, 4);    // add aborted in T4
    run_instr(32'h08FFFFFF, 0, 0, 0, -1);   // ldi
    run_instr(32'h10800004, 2, 0, TO - 1, -1);
    run_instr(32'h00800010, 0, TO, 0, -1);
    run_instr(32'h19890000, TO, 0, 0, -1);
    run_instr(32'h58000001, TO - 1, 0, 0, -1);
    run_instr(32'h68000007, 0, 0, 0, -1);
    run_instr(32'h70040000, 0, 0, 0, -1);
    run_instr(32'hD8000000, 0, 0, 0, -1);   // halt

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 19);
      op = (r < 15) ? r : (r == 15) ? 26 : (r == 16) ? 27 : $urandom_range(15, 31);
      s1 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      s6 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      s7 = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 7) : -1;
      run_instr({5'(op), 27'($urandom)}, s1, s6, s7, ab);
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
